// File: rtl/enc_pkg.sv
// enc_pkg: shared enums for the one-hot encoder pipeline.
// Result structs are declared per module so the index width follows N.
package enc_pkg;

  typedef enum logic {
    ENC_STRICT = 1'b0,
    ENC_PRIO   = 1'b1
  } enc_mode_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/onehot_enc_core.sv
// onehot_enc_core: combinational N-bit one-hot / priority decode.
// Result layout is {idx, err, multi}.
module onehot_enc_core
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_vec,
  input  enc_mode_e    i_mode,
  output logic [W+1:0] o_res
);

  typedef struct packed {
    logic [W-1:0] idx;
    logic         err;
    logic         multi;
  } enc_res_t;

  logic [N-1:0] w_low;
  logic [W-1:0] w_low_idx;
  logic         w_any;
  logic         w_multi;
  enc_res_t     w_res;

  // Two's-complement trick isolates the lowest set bit.
  assign w_low   = i_vec & (~i_vec + N'(1));
  assign w_any   = |i_vec;
  assign w_multi = |(i_vec & ~w_low);

  always_comb begin
    w_low_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_low[i]) w_low_idx = W'(i);
    end
  end

  always_comb begin
    w_res       = '0;
    w_res.multi = w_multi;
    unique case (1'b1)
      (i_mode == ENC_PRIO): begin
        w_res.err = !w_any;
        w_res.idx = w_low_idx;
      end
      default: begin
        w_res.err = !w_any || w_multi;
        w_res.idx = w_res.err ? '0 : w_low_idx;
      end
    endcase
  end

  assign o_res = w_res;

endmodule

// File: rtl/onehot_enc_pipe.sv
// onehot_enc_pipe: decoded one-hot index behind a two-entry skid buffer
// with registered in_ready and a saturating error counter.
module onehot_enc_pipe
  import enc_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int CNT_W = 8,
  localparam int W     = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     dat_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     dat_out,
  output logic             err,
  output logic             multi,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             clr_cnt
);

  typedef struct packed {
    logic [W-1:0] idx;
    logic         err;
    logic         multi;
  } enc_res_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  skid_state_e      r_state;
  skid_state_e      w_next;
  enc_res_t         w_dec;
  enc_res_t         r_out;
  enc_res_t         r_skid;
  logic             r_ready;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push;
  logic             w_pop;
  logic             w_err_push;

  onehot_enc_core #(
    .N(N)
  ) u_core (
    .i_vec  (dat_in),
    .i_mode (enc_mode_e'(mode)),
    .o_res  (w_dec)
  );

  // Masking by rst keeps handshakes dead in the reset cycle;
  // r_ready itself resets high so acceptance resumes right after.
  assign in_ready   = r_ready & ~rst;
  assign out_valid  = (r_state != EMPTY) & ~rst;
  assign err_cnt    = rst ? '0 : r_cnt;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = out_valid & out_ready;
  assign w_err_push = w_push & w_dec.err;

  assign dat_out = r_out.idx;
  assign err     = r_out.err;
  assign multi   = r_out.multi;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      EMPTY: if (w_push) w_next = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_next = TWO;
        else if (w_pop && !w_push) w_next = EMPTY;
      end
      TWO:   if (w_pop) w_next = ONE;
      default: w_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != TWO);
      if (w_push && (r_state == EMPTY || w_pop))
        r_out <= w_dec;
      else if (w_pop && r_state == TWO)
        r_out <= r_skid;
      if (w_push && !w_pop && r_state == ONE)
        r_skid <= w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (clr_cnt)
      r_cnt <= CNT_W'(w_err_push);
    else if (w_err_push && r_cnt != CNT_MAX)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: tb/tb_onehot_enc_pipe.sv
// tb_onehot_enc_pipe: directed vectors plus random traffic against a
// depth-2 FIFO reference with saturating counters (CNT_W = 8 and 2).
module tb_onehot_enc_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       mode = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_cnt = 1'b0;
  logic [7:0] dat_in = 8'h00;

  logic       in_ready, out_valid, err, multi;
  logic [2:0] dat_out;
  logic [7:0] err_cnt;
  logic       in_ready2, out_valid2, err2, multi2;
  logic [2:0] dat_out2;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int pushes = 0;
  int cnt8   = 0;
  int cnt2   = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic       err;
    logic       multi;
  } exp_t;

  typedef struct {
    logic [7:0] dat;
    logic       mode;
    exp_t       exp;
  } vec_t;

  exp_t q[$];
  vec_t tbl[13];

  onehot_enc_pipe #(.N(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dat_in(dat_in), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .dat_out(dat_out), .err(err),
    .multi(multi), .err_cnt(err_cnt), .clr_cnt(clr_cnt)
  );

  onehot_enc_pipe #(.N(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .dat_in(dat_in), .mode(mode), .out_valid(out_valid2),
    .out_ready(out_ready), .dat_out(dat_out2), .err(err2),
    .multi(multi2), .err_cnt(err_cnt2), .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic exp_t ref_enc(input logic [7:0] v, input logic m);
    exp_t r;
    int   ones;
    logic [7:0] low;
    ones    = $countones(v);
    low     = v & (~v + 8'd1);
    r       = '0;
    r.multi = (ones > 1);
    if (!m) begin
      r.err = (ones != 1);
      r.idx = r.err ? 3'd0 : 3'($clog2(v));
    end else begin
      r.err = (v == 8'h00);
      r.idx = r.err ? 3'd0 : 3'($clog2(low));
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [7:0] d, input logic m,
                              input int idx, input logic e,
                              input logic mu);
    vec_t v;
    v.dat       = d;
    v.mode      = m;
    v.exp.idx   = 3'(idx);
    v.exp.err   = e;
    v.exp.multi = mu;
    return v;
  endfunction

  // Reference: bounded FIFO of decoded beats plus counters.
  always @(negedge clk) begin
    exp_t r;
    if (rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_err_cnt2", err_cnt2, 0);
      q.delete();
      cnt8 = 0;
      cnt2 = 0;
    end else begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      chk("err_cnt", err_cnt, cnt8);
      chk("err_cnt2", err_cnt2, cnt2);
      if (out_valid && q.size() > 0) begin
        chk("dat_out", dat_out, q[0].idx);
        chk("err", err, q[0].err);
        chk("multi", multi, q[0].multi);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        pops++;
      end
      r = ref_enc(dat_in, mode);
      if (in_valid && in_ready) begin
        q.push_back(r);
        pushes++;
      end
      if (clr_cnt) begin
        cnt8 = (in_valid && in_ready && r.err) ? 1 : 0;
        cnt2 = cnt8;
      end else if (in_valid && in_ready && r.err) begin
        if (cnt8 < 255) cnt8++;
        if (cnt2 < 3)   cnt2++;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic m);
    int n;
    n        = 0;
    in_valid = 1'b1;
    dat_in   = d;
    mode     = m;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck 0 for dat %0h", d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int u0;
    int sel;

    for (int i = 0; i < 8; i++) tbl[i] = mk(8'(1 << i), 1'b0, i, 0, 0);
    tbl[8]  = mk(8'h00, 1'b0, 0, 1, 0);
    tbl[9]  = mk(8'h0C, 1'b0, 0, 1, 1);
    tbl[10] = mk(8'h0C, 1'b1, 2, 0, 1);
    tbl[11] = mk(8'hA0, 1'b1, 5, 0, 1);
    tbl[12] = mk(8'h00, 1'b1, 0, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_dat_out", dat_out, 0);
    chk("reset_err", err, 0);
    chk("reset_multi", multi, 0);
    chk("reset_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 13; i++) begin
      send(tbl[i].dat, tbl[i].mode);
      @(negedge clk);
      chk("tbl_valid", out_valid, 1);
      chk("tbl_idx", dat_out, tbl[i].exp.idx);
      chk("tbl_err", err, tbl[i].exp.err);
      chk("tbl_multi", multi, tbl[i].exp.multi);
      if (i == 7)  chk("tbl_cnt_sweep", err_cnt, 0);
      if (i == 9)  chk("tbl_cnt_strict", err_cnt, 2);
      if (i == 12) chk("tbl_cnt_prio", err_cnt, 3);
      @(posedge clk);
      #1;
    end

    out_ready = 1'b0;
    p0 = pops;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    in_valid = 1'b1;
    dat_in   = 8'h04;
    mode     = 1'b0;
    @(negedge clk);
    chk("bp_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_hold", in_ready, 0);
    chk("bp_head", dat_out, 0);
    chk("bp_head_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h04, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_pop_count", pops - p0, 3);

    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_only", err_cnt, 0);
    @(posedge clk);
    #1;
    repeat (5) send(8'h00, 1'b0);
    @(negedge clk);
    chk("sat_cnt2", err_cnt2, 3);
    chk("sat_cnt8", err_cnt, 5);
    @(posedge clk);
    #1;
    clr_cnt = 1'b1;
    send(8'h00, 1'b0);
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_push_cnt2", err_cnt2, 1);
    chk("clr_push_cnt8", err_cnt, 1);
    @(posedge clk);
    #1;

    out_ready = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    @(negedge clk);
    chk("mid_two", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_ready_back", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    u0       = pushes;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      dat_in = 8'($urandom);
      mode   = 1'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("throughput", pushes - u0, 50);

    for (int i = 0; i < 3000; i++) begin
      sel       = $urandom_range(0, 3);
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      clr_cnt   = ($urandom_range(0, 31) == 0);
      if (sel == 0)      dat_in = 8'h00;
      else if (sel == 1) dat_in = 8'(1 << $urandom_range(0, 7));
      else               dat_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    clr_cnt   = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/onehot_enc_pipe.md
# onehot_enc_pipe

Parametrised, registered successor to the lab-2 8-to-3 one-hot encoder. It accepts an N-bit request vector over a valid/ready handshake and returns its binary index with an error flag. Two decode modes are selectable per beat: strict one-hot or lowest-index priority. A two-entry skid buffer keeps full throughput with a registered `in_ready`, and a saturating error counter is provided. It sits between request sources (lab switch/arbiter logic) and downstream index consumers.

## Interface
- `N`, default 8: input vector width, ≥ 2.
- `W`, default `$clog2(N)`: index width; localparam, not overridable.
- `CNT_W`, default 8: error-counter width, ≥ 1.

- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input accept; registered
- `dat_in`  in  N  request vector
- `mode`  in  1  per-beat mode; sampled with `dat_in`: 0 = strict, 1 = priority
- `out_valid`  out  1  output beat valid
- `out_ready`  in  1  downstream accept
- `dat_out`  out  W  encoded index
- `err`  out  1  beat error flag; travels with `dat_out`
- `multi`  out  1  more than one bit set; travels with `dat_out`
- `err_cnt`  out  CNT_W  saturating count of accepted error beats
- `clr_cnt`  in  1  synchronous clear of `err_cnt`

## Operation
- Decode, strict mode: exactly one bit set gives `dat_out` = its index and `err` = 0. Any other vector (zero bits or several bits) gives `dat_out` = 0 and `err` = 1.
- Decode, priority mode: the lowest set bit wins. `err` = 1 only when `dat_in` = 0, and then `dat_out` = 0. Several set bits are not an error.
- `multi` = popcount(`dat_in`) > 1 in both modes.
- Decode is done on the input side. The skid buffer stores {`dat_out`, `err`, `multi`}.
- Buffer FSM states:
  - EMPTY: `out_valid` = 0.
  - ONE: a beat sits in the output register.
  - TWO: the output register and the skid register are both full.
- Transitions (push = `in_valid & in_ready`, pop = `out_valid & out_ready`):
  - EMPTY, push → ONE.
  - ONE, push & !pop → TWO.
  - ONE, pop & !push → EMPTY.
  - ONE, push & pop → ONE; the new beat goes straight into the output register.
  - TWO, pop → ONE; the skid entry moves to the output register.
  - TWO, no push is possible.
- `in_ready` is registered. It is 1 in EMPTY and ONE, and 0 in TWO. The value for the next cycle is computed from the next state.
- Output ordering is strictly FIFO. `out_valid` must not drop and payload must not change while `out_valid & !out_ready`.
- `err_cnt` increments by 1 on each push whose decoded `err` = 1. It saturates at 2^CNT_W − 1.
- If `clr_cnt` and an error push occur in the same cycle, `err_cnt` becomes 1. `clr_cnt` alone gives 0.

## Timing
- Reset values: state EMPTY, `out_valid` = 0, `in_ready` = 0, `dat_out` = 0, `err` = 0, `multi` = 0, `err_cnt` = 0.
- `in_ready` rises on the first cycle after `rst` deasserts.
- Latency: a beat pushed in cycle t is presented in cycle t+1.
- Throughput: one beat per cycle with `out_ready` held high.
- When `out_ready` is stalled: at most 2 beats are accepted, and `in_ready` goes low one cycle after the second push.
- `rst` asserted mid-operation: buffered beats are discarded and `err_cnt` is cleared. No output handshake completes in the reset cycle.
- `mode` and `dat_in` are don't-care when `in_valid` = 0.

## Structure
- Package `enc_pkg` holds:
  - enum `enc_mode_e` {ENC_STRICT = 1'b0, ENC_PRIO = 1'b1};
  - enum `skid_state_e` {EMPTY, ONE, TWO};
  - packed struct `enc_res_t` {idx, err, multi}. The struct is parametrised via the W-sized field in the module, or declared locally if package parametrisation is unavailable.
- Sub-module `onehot_enc_core` (parameter N) is a purely combinational decode: vector + mode → `enc_res_t`.
- The top level holds the skid FSM, the registers and the counter.

## Test plan
All scenarios use N = 8.
- Strict sweep: push `dat_in` = 8'h01, 8'h02 … 8'h80 with `mode` = 0 and `out_ready` = 1. Required: `dat_out` = 0..7, `err` = 0, `multi` = 0, each one cycle after its push; `err_cnt` stays 0.
- Strict errors: push 8'h00, then 8'h0C, with `mode` = 0. Required: `dat_out` = 0 and `err` = 1 both times; `multi` = 0 then 1; `err_cnt` = 2.
- Priority: push 8'h0C, 8'hA0, 8'h00 with `mode` = 1. Required:
  - 8'h0C → `dat_out` = 2, `err` = 0, `multi` = 1.
  - 8'hA0 → `dat_out` = 5, `err` = 0, `multi` = 1.
  - 8'h00 → `dat_out` = 0, `err` = 1.
- Backpressure: `out_ready` = 0 while pushing 8'h01, 8'h02, 8'h04 back to back. Required: the first two are accepted and `in_ready` = 0 from the third cycle. After `out_ready` = 1, the outputs are 0, 1, 2 in order and the third beat is accepted with no loss or duplication.
- Counter: with CNT_W = 2, push 5 strict-error beats. Required: `err_cnt` saturates at 3. Then assert `clr_cnt` together with an error push. Required: `err_cnt` = 1.
- Reset mid-stream: reach state TWO, then pulse `rst` for one cycle. Required: `out_valid` = 0, `err_cnt` = 0, `in_ready` = 0 during reset and 1 on the next cycle, and no stale beat appears afterwards.
